// File: rtl/adder_pkg.sv
// Shared defaults and helpers for the segmented pipelined adder.
package adder_pkg;

  localparam int ADDER_WIDTH = 16;
  localparam int ADDER_SEG   = 4;

  function automatic int num_stages(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/Full_Adder.sv
// One-bit full adder cell used to build each pipeline segment.
module Full_Adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/adder_seg.sv
// SEG-bit ripple-carry adder; one instance forms the arithmetic of one pipeline stage.
module adder_seg
  import adder_pkg::*;
#(
  parameter int SEG = ADDER_SEG
) (
  input  logic [SEG-1:0] A,
  input  logic [SEG-1:0] B,
  input  logic           CIN,
  output logic [SEG-1:0] S,
  output logic           COUT
);

  logic [SEG:0] carry;

  assign carry[0] = CIN;
  assign COUT     = carry[SEG];

  for (genvar gi = 0; gi < SEG; gi++) begin : g_bit
    Full_Adder u_fa (
      .a_i (A[gi]),
      .b_i (B[gi]),
      .c_i (carry[gi]),
      .s_o (S[gi]),
      .c_o (carry[gi+1])
    );
  end

endmodule

// File: rtl/adder_pipe.sv
// Carry-pipelined adder: SEG bits per stage, operands skewed in, sums de-skewed out,
// with a valid/ready stall that freezes the whole pipe when the output is blocked.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int SEG   = ADDER_SEG
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF
);

  localparam int NSTG = num_stages(WIDTH, SEG);

  logic                      adv;
  logic [NSTG-1:0]           vld_q;
  logic [NSTG-1:0]           cy_q;
  logic                      ovf_q;
  logic                      ovf_d;
  logic [NSTG-1:0][SEG-1:0]  seg_a;
  logic [NSTG-1:0][SEG-1:0]  seg_b;
  logic [NSTG-1:0][SEG-1:0]  seg_sum;
  logic [NSTG-1:0]           seg_cin;
  logic [NSTG-1:0]           seg_cout;

  // The only stall condition is a valid result the consumer refuses.
  assign adv       = ~(vld_q[NSTG-1] & ~OUT_READY);
  assign IN_READY  = adv;
  assign OUT_VALID = vld_q[NSTG-1];
  assign COUT      = cy_q[NSTG-1];
  assign OVF       = ovf_q;

  assign seg_cin[0] = CIN;
  for (genvar gi = 1; gi < NSTG; gi++) begin : g_cin
    assign seg_cin[gi] = cy_q[gi-1];
  end

  // Carry into the MSB is recovered from the top bit's operands and sum.
  assign ovf_d = seg_a[NSTG-1][SEG-1] ^ seg_b[NSTG-1][SEG-1]
               ^ seg_sum[NSTG-1][SEG-1] ^ seg_cout[NSTG-1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      vld_q[0] <= IN_VALID;
      for (int k = 1; k < NSTG; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      cy_q  <= seg_cout;
      ovf_q <= ovf_d;
    end
  end

  for (genvar gi = 0; gi < NSTG; gi++) begin : g_seg
    localparam int SDEPTH = NSTG - gi;

    logic [SEG-1:0] sum_q [SDEPTH];

    if (gi == 0) begin : g_nodly
      assign seg_a[gi] = A[SEG-1:0];
      assign seg_b[gi] = B[SEG-1:0];
    end else begin : g_dly
      // Segment gi waits gi cycles so it meets the carry produced by stage gi-1.
      logic [SEG-1:0] a_q [gi];
      logic [SEG-1:0] b_q [gi];

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          for (int i = 0; i < gi; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
          end
        end else if (adv) begin
          a_q[0] <= A[gi*SEG +: SEG];
          b_q[0] <= B[gi*SEG +: SEG];
          for (int i = 1; i < gi; i++) begin
            a_q[i] <= a_q[i-1];
            b_q[i] <= b_q[i-1];
          end
        end
      end

      assign seg_a[gi] = a_q[gi-1];
      assign seg_b[gi] = b_q[gi-1];
    end

    adder_seg #(
      .SEG (SEG)
    ) u_seg (
      .A    (seg_a[gi]),
      .B    (seg_b[gi]),
      .CIN  (seg_cin[gi]),
      .S    (seg_sum[gi]),
      .COUT (seg_cout[gi])
    );

    // Lower segments finish early and are delayed so all of S leaves together.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        for (int i = 0; i < SDEPTH; i++) begin
          sum_q[i] <= '0;
        end
      end else if (adv) begin
        sum_q[0] <= seg_sum[gi];
        for (int i = 1; i < SDEPTH; i++) begin
          sum_q[i] <= sum_q[i-1];
        end
      end
    end

    assign S[gi*SEG +: SEG] = sum_q[SDEPTH-1];
  end

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits; legal values are a multiple of SEG and at least SEG.
REQ-002 SHALL have parameter SEG, default 4, bits added per pipeline stage; NSTG = WIDTH/SEG stages.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port IN_VALID  input  1  operands A, B, CIN present this cycle.
REQ-006 SHALL have port IN_READY  output  1  block accepts operands this cycle.
REQ-007 SHALL have port A  input  WIDTH  operand A.
REQ-008 SHALL have port B  input  WIDTH  operand B.
REQ-009 SHALL have port CIN  input  1  carry-in.
REQ-010 SHALL have port OUT_VALID  output  1  S, COUT, OVF hold a result.
REQ-011 SHALL have port OUT_READY  input  1  consumer accepts the result this cycle.
REQ-012 SHALL have port S  output  WIDTH  sum, (A+B+CIN) mod 2^WIDTH.
REQ-013 SHALL have port COUT  output  1  unsigned carry-out of bit WIDTH-1.
REQ-014 SHALL have port OVF  output  1  two's-complement overflow: carry into MSB XOR COUT.

Function
REQ-015 SHALL accept a transfer on a rising edge where IN_VALID and IN_READY are both 1; result transfer occurs where OUT_VALID and OUT_READY are both 1.
REQ-016 SHALL compute SEG bits per stage: stage k adds bits [k*SEG +: SEG] using the registered carry from stage k-1; stage 0 uses CIN.
REQ-017 SHALL skew operands: upper segments of A/B are delayed in per-stage registers so that each segment meets its carry in the correct stage; lower sum segments are de-skewed so all WIDTH bits of S appear together.
REQ-018 SHALL present the result of an accepted operand exactly NSTG cycles after acceptance when OUT_READY stays 1 (latency 4 at defaults).
REQ-019 SHALL sustain one accepted operand per cycle with OUT_READY held 1.
REQ-020 SHALL drive IN_READY = NOT (OUT_VALID AND NOT OUT_READY); when IN_READY is 0, every stage register, including valid bits, holds its value.
REQ-021 SHALL hold S, COUT, OVF stable while OUT_VALID is 1 and OUT_READY is 0.
REQ-022 SHALL propagate bubbles: a stage whose valid bit is 0 advances normally; data in invalid stages is don't-care but SHALL NOT assert OUT_VALID.
REQ-023 SHALL keep results strictly in acceptance order; no drop, no duplication.
REQ-024 SHALL wrap on unsigned overflow: e.g. 0xFFFF+0x0001+0 gives S=0x0000, COUT=1.
REQ-025 SHALL have no combinational path from IN_VALID to OUT_VALID; OUT_READY to IN_READY is the only combinational input-to-output path.

Reset
REQ-026 SHALL, while RST_N=0, clear all stage valid bits; OUT_VALID=0, S=0, COUT=0, OVF=0 immediately, regardless of CLK.
REQ-027 SHALL discard in-flight operations on reset mid-operation; no result from before reset appears afterwards.
REQ-028 SHALL drive IN_READY=1 during and after reset, because OUT_VALID=0.

Structure
REQ-029 SHALL place the defaults ADDER_WIDTH=16 and ADDER_SEG=4 in package adder_pkg.
REQ-030 SHALL use one sub-module adder_seg (a SEG-bit ripple adder of Full_Adder instances with CIN/COUT), instantiated NSTG times with a generate loop.
REQ-031 SHALL keep the stall logic and the skew/de-skew registers in adder_pipe itself.

Verification (WIDTH=16, SEG=4 unless noted)
REQ-032 SHALL cover a single op: A=0x1234, B=0x4321, CIN=0 -> after 4 cycles S=0x5555, COUT=0, OVF=0.
REQ-033 SHALL cover carry ripple across all stages: A=0xFFFF, B=0x0000, CIN=1 -> S=0x0000, COUT=1, OVF=0.
REQ-034 SHALL cover signed overflow: A=0x7FFF, B=0x0001, CIN=0 -> S=0x8000, COUT=0, OVF=1.
REQ-035 SHALL cover back-pressure: stream 8 ops back-to-back with OUT_READY=0 for 3 cycles mid-stream -> IN_READY=0 exactly while stalled, all 8 results in order, S stable during the stall.
REQ-036 SHALL cover reset mid-operation: 3 ops in flight, RST_N=0 for 1 cycle -> OUT_VALID=0 at once and no stale results appear afterwards.
REQ-037 SHALL cover WIDTH=32, SEG=8 with 1000 random ops and random IN_VALID/OUT_READY -> all results match a reference model, in order.
